// File: rtl/vec_int_to_float.sv
// Handshaked int32/uint32 -> float32 converter for a three-component vector.
// One shared converter is time-multiplexed over x, y and z, one component per cycle.
module vec_int_to_float #(
    parameter int SIGNED_IN = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic [31:0] in_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_z
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  idx;
    logic [31:0] cap_x;
    logic [31:0] cap_y;
    logic [31:0] cap_z;
    logic [31:0] conv_in;
    logic [31:0] conv_out;
    logic        accept;

    // Normalise the magnitude so its leading one sits at bit 31; everything below
    // the 23 kept fraction bits then supplies guard (bit 7) and sticky (bits 6:0).
    function automatic logic [31:0] int_to_f32(input logic [31:0] v);
        logic        sign;
        logic [31:0] mag;
        logic [31:0] norm;
        logic [4:0]  lead;
        logic        round_up;
        logic [23:0] mant;
        logic [7:0]  expo;
        sign = (SIGNED_IN != 0) && v[31];
        mag  = sign ? (~v + 32'd1) : v;
        lead = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) lead = 5'(i);
        end
        norm     = mag << (5'd31 - lead);
        round_up = norm[7] && ((|norm[6:0]) || norm[8]);
        mant     = {1'b0, norm[30:8]} + {23'd0, round_up};
        // A carry into mant[23] leaves mant[22:0] all zero, which is the cleared fraction.
        expo     = 8'd127 + {3'd0, lead} + {7'd0, mant[23]};
        if (mag == 32'd0) return 32'd0;
        return {sign, expo, mant[22:0]};
    endfunction

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst_in;
                if (in_valid) state_nxt = CONV;
            end
            CONV: begin
                if (idx == 2'd2) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst_in;
                if (out_ready) state_nxt = in_valid ? CONV : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        case (idx)
            2'd0:    conv_in = cap_x;
            2'd1:    conv_in = cap_y;
            default: conv_in = cap_z;
        endcase
    end

    assign conv_out = int_to_f32(conv_in);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: capture registers have no reset; they are always written before they are read.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            cap_x <= in_x;
            cap_y <= in_y;
            cap_z <= in_z;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx   <= 2'd0;
            out_x <= 32'd0;
            out_y <= 32'd0;
            out_z <= 32'd0;
        end else if (accept) begin
            idx <= 2'd0;
        end else if (state == CONV) begin
            case (idx)
                2'd0:    out_x <= conv_out;
                2'd1:    out_y <= conv_out;
                default: out_z <= conv_out;
            endcase
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_vec_int_to_float.sv
// Scoreboard bench for vec_int_to_float: signed and unsigned instances run in lockstep
// on shared stimulus; expected vectors are queued at the handshake and popped on output.
module tb_vec_int_to_float;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_x, in_y, in_z;
    logic        in_ready_s, in_ready_u;
    logic        out_valid_s, out_valid_u;
    logic [31:0] out_x_s, out_y_s, out_z_s;
    logic [31:0] out_x_u, out_y_u, out_z_u;

    typedef struct {
        logic [95:0] vec;
        int          cyc;
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out_s = 0;
    bit   seen_s = 1'b0;
    bit   seen_u = 1'b0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    vec_int_to_float #(.SIGNED_IN(1)) u_dut_s (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_x(out_x_s), .out_y(out_y_s), .out_z(out_z_s)
    );

    vec_int_to_float #(.SIGNED_IN(0)) u_dut_u (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_x(out_x_u), .out_y(out_y_u), .out_z(out_z_u)
    );

    // Reference conversion by integer division-style rounding on a wide magnitude.
    function automatic logic [31:0] ref_f32(input logic [31:0] v, input bit sgn);
        bit              s;
        longint unsigned m, q, rem, half;
        int              p, sh;
        s = sgn && v[31];
        m = {32'd0, v};
        if (s) m = 64'h1_0000_0000 - m;
        if (m == 0) return 32'd0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                p++;
            end
        end
        return {s, 8'(127 + p), q[22:0]};
    endfunction

    function automatic logic [95:0] ref_vec(input logic [31:0] x, y, z, input bit sgn);
        return {ref_f32(x, sgn), ref_f32(y, sgn), ref_f32(z, sgn)};
    endfunction

    task automatic mon_s();
        forever begin
            @(negedge clk_in);
            if (!rst_in && out_valid_s) begin
                n_checks++;
                if (q_s.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_s: got %h, expected no output", {out_x_s, out_y_s, out_z_s});
                end else begin
                    if ({out_x_s, out_y_s, out_z_s} !== q_s[0].vec) begin
                        n_fail++;
                        $display("FAIL data_s: got %h, expected %h", {out_x_s, out_y_s, out_z_s}, q_s[0].vec);
                    end
                    if (!seen_s) begin
                        n_checks++;
                        if (cyc !== q_s[0].cyc) begin
                            n_fail++;
                            $display("FAIL latency_s: valid at cycle %0d, expected cycle %0d", cyc, q_s[0].cyc);
                        end
                        seen_s = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q_s.pop_front());
                        seen_s = 1'b0;
                        n_out_s++;
                    end
                end
            end
        end
    endtask

    task automatic mon_u();
        forever begin
            @(negedge clk_in);
            if (!rst_in && out_valid_u) begin
                n_checks++;
                if (q_u.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_u: got %h, expected no output", {out_x_u, out_y_u, out_z_u});
                end else begin
                    if ({out_x_u, out_y_u, out_z_u} !== q_u[0].vec) begin
                        n_fail++;
                        $display("FAIL data_u: got %h, expected %h", {out_x_u, out_y_u, out_z_u}, q_u[0].vec);
                    end
                    if (!seen_u) begin
                        n_checks++;
                        if (cyc !== q_u[0].cyc) begin
                            n_fail++;
                            $display("FAIL latency_u: valid at cycle %0d, expected cycle %0d", cyc, q_u[0].cyc);
                        end
                        seen_u = 1'b1;
                    end
                    if (out_ready) begin
                        void'(q_u.pop_front());
                        seen_u = 1'b0;
                    end
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_full(input logic [31:0] x, y, z, input logic [95:0] es, eu, output int waited);
        bit accepted = 1'b0;
        int hs_cyc = 0;
        waited   = 0;
        in_valid = 1'b1;
        in_x = x; in_y = y; in_z = z;
        while (!accepted && waited < 100) begin
            @(negedge clk_in);
            if (in_ready_s) begin
                accepted = 1'b1;
                hs_cyc   = cyc;
            end else begin
                waited++;
            end
            @(posedge clk_in);
            #1;
        end
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL handshake_timeout: waited %0d cycles, expected acceptance within 100", waited);
        end else begin
            q_s.push_back('{vec: es, cyc: hs_cyc + 4});
            q_u.push_back('{vec: eu, cyc: hs_cyc + 4});
        end
        in_valid = 1'b0;
        in_x = $urandom; in_y = $urandom; in_z = $urandom;
    endtask

    task automatic send(input logic [31:0] x, y, z);
        int w;
        send_full(x, y, z, ref_vec(x, y, z, 1'b1), ref_vec(x, y, z, 1'b0), w);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q_s.size() != 0 || q_u.size() != 0) && n < 200) begin
            @(posedge clk_in);
            n++;
        end
        @(posedge clk_in);
        #1;
        n_checks++;
        if (q_s.size() != 0 || q_u.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d vectors pending, expected 0", q_s.size(), q_u.size());
        end
    endtask

    task automatic test_reset();
        rst_in    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x = '0; in_y = '0; in_z = '0;
        #1 rst_in = 1'b1;
        #1;
        n_checks++;
        if ({in_ready_s, out_valid_s} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got ready/valid %b, expected 00", {in_ready_s, out_valid_s});
        end
        n_checks++;
        if ({out_x_s, out_y_s, out_z_s} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected 0", {out_x_s, out_y_s, out_z_s});
        end
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if ({in_ready_s, out_valid_s} !== 2'b10) begin
            n_fail++;
            $display("FAIL release_flags: got ready/valid %b, expected 10", {in_ready_s, out_valid_s});
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_basic();
        int w;
        send_full(32'd10, 32'd3, 32'hFFFF_FFFF, {32'h4120_0000, 32'h4040_0000, 32'hBF80_0000},
                  ref_vec(32'd10, 32'd3, 32'hFFFF_FFFF, 1'b0), w);
        wait_drain();
    endtask

    task automatic test_rounding();
        int w;
        send_full(32'd16777217, 32'd16777219, 32'h7FFF_FFFF, {32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000},
                  ref_vec(32'd16777217, 32'd16777219, 32'h7FFF_FFFF, 1'b0), w);
        send_full(32'd0, 32'h8000_0000, 32'd1, {32'h0000_0000, 32'hCF00_0000, 32'h3F80_0000},
                  ref_vec(32'd0, 32'h8000_0000, 32'd1, 1'b0), w);
        wait_drain();
    endtask

    task automatic test_unsigned();
        int w;
        send_full(32'hFFFF_FFFF, 32'h8000_0000, 32'd5, ref_vec(32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 1'b1),
                  {32'h4F80_0000, 32'h4F00_0000, 32'h40A0_0000}, w);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int n0 = n_out_s;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send($urandom, $urandom >> (i * 6), -(i * 1000003 + 7));
        end
        wait_drain();
        n_checks++;
        if (n_out_s - n0 !== 5) begin
            n_fail++;
            $display("FAIL stream_count: got %0d outputs, expected 5", n_out_s - n0);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int n = 0;
        out_ready = 1'b0;
        send(32'd123456789, 32'hFFFF_FF00, 32'd33554435);
        while (!out_valid_s && n < 10) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        in_valid = 1'b1;
        in_x = 32'hDEAD_BEEF; in_y = 32'h1234_5678; in_z = 32'hCAFE_F00D;
        repeat (10) begin
            @(negedge clk_in);
            n_checks++;
            if ({out_valid_s, in_ready_s} !== 2'b10) begin
                n_fail++;
                $display("FAIL hold_flags: got valid/ready %b, expected 10", {out_valid_s, in_ready_s});
            end
            @(posedge clk_in);
            #1;
        end
        out_ready = 1'b1;
        send_full(32'd42, 32'hFFFF_FFD6, 32'd16777216, ref_vec(32'd42, 32'hFFFF_FFD6, 32'd16777216, 1'b1),
                  ref_vec(32'd42, 32'hFFFF_FFD6, 32'd16777216, 1'b0), w);
        n_checks++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL release_accept: waited %0d cycles, expected 0", w);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_conv();
        send(32'd99, 32'd98, 32'd97);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        q_s.delete();
        q_u.delete();
        seen_s = 1'b0;
        seen_u = 1'b0;
        n_checks++;
        if ({in_ready_s, out_valid_s} !== 2'b00 || {out_x_s, out_y_s, out_z_s} !== 96'd0) begin
            n_fail++;
            $display("FAIL abort_state: got ready/valid %b data %h, expected 00 and 0",
                     {in_ready_s, out_valid_s}, {out_x_s, out_y_s, out_z_s});
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            n_checks++;
            if ({in_ready_s, out_valid_s} !== 2'b10) begin
                n_fail++;
                $display("FAIL post_abort_flags: got ready/valid %b, expected 10", {in_ready_s, out_valid_s});
            end
        end
        @(posedge clk_in);
        #1;
        send(32'd7, 32'hFFFF_FFF8, 32'd123456789);
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            mon_s();
            mon_u();
        join_none
        test_reset();
        test_basic();
        test_rounding();
        test_unsigned();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
